// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings and arbiter state constants
// shared by the sdram_* engines and the bus arbiter.
package sdram_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   // One-hot arbiter states
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_AREF  = 5'b00100,
      S_WRITE = 5'b01000,
      S_READ  = 5'b10000
   } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM pins after init and hands
// the bus to refresh, write or read engines one at a time.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int         ADDR_W  = 13,
   parameter int         BA_W    = 2,
   parameter logic [3:0] CMD_NOP = 4'b0111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              init_end,
   input  logic              aref_req,
   input  logic [3:0]        aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              aref_end,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic              wr_end,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic              rd_end,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              aref_pend,
   output logic [3:0]        sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BA_W-1:0]   sdram_ba
);

   arb_state_t        state_c;
   arb_state_t        state_n;
   logic              pend_n;
   logic [3:0]        cmd_n;
   logic [ADDR_W-1:0] addr_n;
   logic [BA_W-1:0]   ba_n;

   // Next state: fixed priority refresh > write > read,
   // every operation returns through ARBIT
   always_comb begin
      state_n = state_c;
      unique case (state_c)
         S_IDLE:  if (init_end) state_n = S_ARBIT;
         S_ARBIT: begin
            if (aref_pend)   state_n = S_AREF;
            else if (wr_req) state_n = S_WRITE;
            else if (rd_req) state_n = S_READ;
         end
         S_AREF:  if (aref_end) state_n = S_ARBIT;
         S_WRITE: if (wr_end)   state_n = S_ARBIT;
         S_READ:  if (rd_end)   state_n = S_ARBIT;
         default: state_n = S_IDLE;
      endcase
   end

   // Refresh owed: a new request beats a same-cycle completion
   always_comb begin
      pend_n = aref_pend;
      if (aref_end) pend_n = 1'b0;
      if (aref_req && state_c != S_IDLE) pend_n = 1'b1;
   end

   // Pin mux keyed on the upcoming state so the engine's
   // command lands on the pins one clock after it is driven
   always_comb begin
      cmd_n  = CMD_NOP;
      addr_n = '0;
      ba_n   = '0;
      unique case (state_n)
         S_IDLE: begin
            cmd_n  = init_cmd;
            addr_n = init_addr;
         end
         S_AREF: begin
            cmd_n  = aref_cmd;
            addr_n = aref_addr;
         end
         S_WRITE: begin
            cmd_n  = wr_cmd;
            addr_n = wr_addr;
            ba_n   = wr_ba;
         end
         S_READ: begin
            cmd_n  = rd_cmd;
            addr_n = rd_addr;
            ba_n   = rd_ba;
         end
         default: begin
            cmd_n  = CMD_NOP;
            addr_n = '0;
            ba_n   = '0;
         end
      endcase
   end

   // State, grants, pending flag and pins, all registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_c    <= S_IDLE;
         aref_en    <= 1'b0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         aref_pend  <= 1'b0;
         sdram_cmd  <= CMD_NOP;
         sdram_addr <= '0;
         sdram_ba   <= '0;
      end else begin
         state_c    <= state_n;
         aref_en    <= (state_n == S_AREF);
         wr_en      <= (state_n == S_WRITE);
         rd_en      <= (state_n == S_READ);
         aref_pend  <= pend_n;
         sdram_cmd  <= cmd_n;
         sdram_addr <= addr_n;
         sdram_ba   <= ba_n;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of grant order, refresh
// pending flag, pin timing and asynchronous reset.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   localparam int ADDR_W = 13;
   localparam int BA_W   = 2;

   logic              clk;
   logic              rst_n;
   logic [3:0]        init_cmd;
   logic [ADDR_W-1:0] init_addr;
   logic              init_end;
   logic              aref_req;
   logic [3:0]        aref_cmd;
   logic [ADDR_W-1:0] aref_addr;
   logic              aref_end;
   logic              wr_req;
   logic [3:0]        wr_cmd;
   logic [ADDR_W-1:0] wr_addr;
   logic [BA_W-1:0]   wr_ba;
   logic              wr_end;
   logic              rd_req;
   logic [3:0]        rd_cmd;
   logic [ADDR_W-1:0] rd_addr;
   logic [BA_W-1:0]   rd_ba;
   logic              rd_end;
   logic              aref_en;
   logic              wr_en;
   logic              rd_en;
   logic              aref_pend;
   logic [3:0]        sdram_cmd;
   logic [ADDR_W-1:0] sdram_addr;
   logic [BA_W-1:0]   sdram_ba;

   int checks = 0;
   int errors = 0;

   sdram_arbiter #(
      .ADDR_W (ADDR_W),
      .BA_W   (BA_W),
      .CMD_NOP(4'b0111)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_cmd  (init_cmd),
      .init_addr (init_addr),
      .init_end  (init_end),
      .aref_req  (aref_req),
      .aref_cmd  (aref_cmd),
      .aref_addr (aref_addr),
      .aref_end  (aref_end),
      .wr_req    (wr_req),
      .wr_cmd    (wr_cmd),
      .wr_addr   (wr_addr),
      .wr_ba     (wr_ba),
      .wr_end    (wr_end),
      .rd_req    (rd_req),
      .rd_cmd    (rd_cmd),
      .rd_addr   (rd_addr),
      .rd_ba     (rd_ba),
      .rd_end    (rd_end),
      .aref_en   (aref_en),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .aref_pend (aref_pend),
      .sdram_cmd (sdram_cmd),
      .sdram_addr(sdram_addr),
      .sdram_ba  (sdram_ba)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // grants packed as {aref_en, wr_en, rd_en}
   function automatic logic [31:0] grants();
      return {29'd0, aref_en, wr_en, rd_en};
   endfunction

   initial begin
      rst_n     = 1'b0;
      init_cmd  = CMD_NOP;
      init_addr = '0;
      init_end  = 1'b0;
      aref_req  = 1'b0;
      aref_cmd  = CMD_NOP;
      aref_addr = '0;
      aref_end  = 1'b0;
      wr_req    = 1'b0;
      wr_cmd    = CMD_NOP;
      wr_addr   = '0;
      wr_ba     = '0;
      wr_end    = 1'b0;
      rd_req    = 1'b0;
      rd_cmd    = CMD_NOP;
      rd_addr   = '0;
      rd_ba     = '0;
      rd_end    = 1'b0;

      tick();
      tick();
      chk("rst_grants", grants(), 32'd0);
      chk("rst_pend",   {31'd0, aref_pend}, 32'd0);
      chk("rst_cmd",    {28'd0, sdram_cmd}, 32'h7);
      chk("rst_addr",   {19'd0, sdram_addr}, 32'd0);
      chk("rst_ba",     {30'd0, sdram_ba}, 32'd0);
      rst_n = 1'b1;

      // 1: init engine owns pins in IDLE; stray inputs ignored
      init_cmd  = CMD_PRE;
      init_addr = 13'h400;
      aref_req  = 1'b1;
      wr_req    = 1'b1;
      rd_end    = 1'b1;
      tick();
      chk("idle_cmd",    {28'd0, sdram_cmd}, {28'd0, CMD_PRE});
      chk("idle_addr",   {19'd0, sdram_addr}, 32'h400);
      chk("idle_pend",   {31'd0, aref_pend}, 32'd0);
      chk("idle_grants", grants(), 32'd0);
      aref_req = 1'b0;
      wr_req   = 1'b0;
      rd_end   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         init_cmd  = (i % 2 == 0) ? CMD_AREF : CMD_MRS;
         init_addr = 13'(i);
         tick();
      end
      chk("idle_track_cmd",  {28'd0, sdram_cmd}, {28'd0, CMD_MRS});
      chk("idle_track_addr", {19'd0, sdram_addr}, 32'd7);
      chk("idle_grants2",    grants(), 32'd0);
      init_end = 1'b1;
      init_cmd = CMD_MRS;
      tick();
      init_end = 1'b0;
      chk("arbit_cmd",    {28'd0, sdram_cmd}, 32'h7);
      chk("arbit_addr",   {19'd0, sdram_addr}, 32'd0);
      chk("arbit_grants", grants(), 32'd0);
      tick();
      chk("arbit_hold", grants(), 32'd0);

      // 2: write wins over read
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      wr_cmd  = CMD_ACT;
      wr_addr = 13'h0F0;
      wr_ba   = 2'd3;
      rd_cmd  = CMD_RD;
      rd_addr = 13'h0AA;
      rd_ba   = 2'd1;
      tick();
      chk("wr_grant",    grants(), 32'b010);
      chk("wr_act_cmd",  {28'd0, sdram_cmd}, {28'd0, CMD_ACT});
      chk("wr_act_ba",   {30'd0, sdram_ba}, 32'd3);
      wr_req = 1'b0;

      // 5: write bus reaches pins one clock later
      wr_cmd  = CMD_WR;
      wr_addr = 13'h155;
      wr_ba   = 2'd2;
      tick();
      chk("wr_cmd",  {28'd0, sdram_cmd}, {28'd0, CMD_WR});
      chk("wr_addr", {19'd0, sdram_addr}, 32'h155);
      chk("wr_ba",   {30'd0, sdram_ba}, 32'd2);

      // 3: refresh request during write becomes pending
      aref_req = 1'b1;
      tick();
      aref_req = 1'b0;
      chk("pend_set",  {31'd0, aref_pend}, 32'd1);
      chk("wr_keeps",  grants(), 32'b010);
      rd_end   = 1'b1;
      aref_end = 1'b0;
      tick();
      rd_end = 1'b0;
      chk("rd_end_ignored", grants(), 32'b010);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      chk("wr_done_grants", grants(), 32'd0);
      chk("wr_done_cmd",    {28'd0, sdram_cmd}, 32'h7);
      chk("wr_done_pend",   {31'd0, aref_pend}, 32'd1);
      aref_cmd  = CMD_AREF;
      aref_addr = 13'h400;
      wr_ba     = 2'd3;
      tick();
      chk("aref_before_rd", grants(), 32'b100);
      chk("aref_cmd",       {28'd0, sdram_cmd}, {28'd0, CMD_AREF});
      chk("aref_addr",      {19'd0, sdram_addr}, 32'h400);
      chk("aref_ba",        {30'd0, sdram_ba}, 32'd0);

      // 4: new request and completion together keep pend set
      aref_req = 1'b1;
      aref_end = 1'b1;
      tick();
      aref_req = 1'b0;
      aref_end = 1'b0;
      chk("both_pend",   {31'd0, aref_pend}, 32'd1);
      chk("both_grants", grants(), 32'd0);
      tick();
      chk("aref_again",  grants(), 32'b100);
      aref_end = 1'b1;
      tick();
      aref_end = 1'b0;
      chk("pend_clear",  {31'd0, aref_pend}, 32'd0);
      chk("aref_done",   grants(), 32'd0);
      tick();
      chk("rd_grant",    grants(), 32'b001);
      chk("rd_cmd",      {28'd0, sdram_cmd}, {28'd0, CMD_RD});
      chk("rd_addr",     {19'd0, sdram_addr}, 32'h0AA);
      chk("rd_ba",       {30'd0, sdram_ba}, 32'd1);
      rd_req = 1'b0;
      tick();
      chk("rd_hold",     grants(), 32'b001);

      // 6: asynchronous reset mid-read
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_grants", grants(), 32'd0);
      chk("arst_cmd",    {28'd0, sdram_cmd}, 32'h7);
      chk("arst_addr",   {19'd0, sdram_addr}, 32'd0);
      chk("arst_ba",     {30'd0, sdram_ba}, 32'd0);
      chk("arst_pend",   {31'd0, aref_pend}, 32'd0);
      tick();
      rst_n     = 1'b1;
      rd_req    = 1'b1;
      wr_req    = 1'b1;
      init_cmd  = CMD_PRE;
      init_addr = 13'h1FF;
      tick();
      tick();
      chk("post_rst_idle", grants(), 32'd0);
      chk("post_rst_cmd",  {28'd0, sdram_cmd}, {28'd0, CMD_PRE});
      chk("post_rst_addr", {19'd0, sdram_addr}, 32'h1FF);
      init_end = 1'b1;
      tick();
      init_end = 1'b0;
      chk("reinit_arbit", grants(), 32'd0);
      tick();
      chk("reinit_wr",    grants(), 32'b010);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
